// File: rtl/audio_mix_stage.sv
// Sample-rate mixer feeding audio_out: per-source gain, saturation,
// speaker idle gating and a fractional sample tick in the clk domain.
module audio_mix_stage #(
  parameter int unsigned CLK_RATE         = 27_000_000,
  parameter int unsigned SAMPLE_RATE      = 44_100,
  parameter int unsigned SPK_HOLD_SAMPLES = 4410,
  parameter logic [15:0] SPK_LEVEL        = 16'h2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ssp_audio_i,
  input  logic [9:0]  mb_audio_l_i,
  input  logic [9:0]  mb_audio_r_i,
  input  logic        speaker_i,
  input  logic [3:0]  ssp_gain_i,
  input  logic [3:0]  mb_gain_i,
  input  logic [3:0]  spk_gain_i,
  input  logic        mute_i,
  output logic [15:0] core_l_o,
  output logic [15:0] core_r_o,
  output logic        sample_valid_o,
  output logic        clip_o
);

  localparam int          CW   = $clog2(SPK_HOLD_SAMPLES + 1);
  localparam logic [31:0] SR   = 32'(SAMPLE_RATE);
  localparam logic [31:0] CR   = 32'(CLK_RATE);
  localparam logic [CW-1:0] HOLD = CW'(SPK_HOLD_SAMPLES);

  // tick generator
  logic [31:0] acc_q, acc_d, acc_sum;
  logic        tick;

  // speaker gate
  logic          spk_q, spk_d, spk_edge, spk_active;
  logic [CW-1:0] idle_q, idle_d;

  // stage 1: products captured at the tick edge
  logic        v1_q, v1_d, mute1_q, mute1_d;
  logic [16:0] ps_q, ps_d, pk_q, pk_d;
  logic [15:0] pml_q, pml_d, pmr_q, pmr_d;
  logic [19:0] ps_full, pk_full;
  logic [18:0] pml_full, pmr_full;

  // stage 2: sums
  logic        v2_q, v2_d, mute2_q, mute2_d;
  logic [18:0] sl_q, sl_d, sr_q, sr_d;

  // stage 3: outputs
  logic [15:0] l_q, l_d, r_q, r_d;
  logic        valid_q, valid_d, clip_q, clip_d;
  logic        sat_l, sat_r;

  // Fractional accumulator: one tick each time it crosses CLK_RATE
  always_comb begin
    acc_sum = acc_q + SR;
    tick    = (acc_sum >= CR);
    acc_d   = tick ? (acc_sum - CR) : acc_sum;
  end

  // Speaker edge detect and idle countdown; a fresh edge beats a tick
  always_comb begin
    spk_d      = speaker_i;
    spk_edge   = spk_q ^ speaker_i;
    spk_active = (idle_q != '0);
    idle_d     = idle_q;
    if (spk_edge) begin
      idle_d = HOLD;
    end else if (tick && spk_active) begin
      idle_d = idle_q - CW'(1);
    end
  end

  // Gain products from the values present in the tick cycle
  always_comb begin
    ps_full  = 20'(ssp_audio_i) * 20'(ssp_gain_i);
    pml_full = 19'({mb_audio_l_i, 5'b0}) * 19'(mb_gain_i);
    pmr_full = 19'({mb_audio_r_i, 5'b0}) * 19'(mb_gain_i);
    pk_full  = 20'(SPK_LEVEL) * 20'(spk_gain_i);
    v1_d     = tick;
    mute1_d  = tick ? mute_i : mute1_q;
    ps_d     = tick ? ps_full[19:3] : ps_q;
    pml_d    = tick ? pml_full[18:3] : pml_q;
    pmr_d    = tick ? pmr_full[18:3] : pmr_q;
    pk_d     = pk_q;
    if (tick) begin
      pk_d = (speaker_i && spk_active) ? pk_full[19:3] : '0;
    end
  end

  // Per-channel sums, wide enough that no combination can wrap
  always_comb begin
    v2_d    = v1_q;
    mute2_d = v1_q ? mute1_q : mute2_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    if (v1_q) begin
      sl_d = 19'(ps_q) + 19'(pml_q) + 19'(pk_q);
      sr_d = 19'(ps_q) + 19'(pmr_q) + 19'(pk_q);
    end
  end

  // Saturate, mute and publish; outputs hold between samples
  always_comb begin
    sat_l   = |sl_q[18:16];
    sat_r   = |sr_q[18:16];
    valid_d = v2_q;
    l_d     = l_q;
    r_d     = r_q;
    clip_d  = clip_q;
    if (v2_q) begin
      if (mute2_q) begin
        l_d = '0;
        r_d = '0;
      end else begin
        l_d    = sat_l ? 16'hFFFF : sl_q[15:0];
        r_d    = sat_r ? 16'hFFFF : sr_q[15:0];
        clip_d = clip_q | sat_l | sat_r;
      end
    end
  end

  // State registers; reset drops any sample in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      spk_q   <= 1'b0;
      idle_q  <= '0;
      v1_q    <= 1'b0;
      mute1_q <= 1'b0;
      ps_q    <= '0;
      pml_q   <= '0;
      pmr_q   <= '0;
      pk_q    <= '0;
      v2_q    <= 1'b0;
      mute2_q <= 1'b0;
      sl_q    <= '0;
      sr_q    <= '0;
      l_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      spk_q   <= spk_d;
      idle_q  <= idle_d;
      v1_q    <= v1_d;
      mute1_q <= mute1_d;
      ps_q    <= ps_d;
      pml_q   <= pml_d;
      pmr_q   <= pmr_d;
      pk_q    <= pk_d;
      v2_q    <= v2_d;
      mute2_q <= mute2_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      l_q     <= l_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
    end
  end

  assign core_l_o       = l_q;
  assign core_r_o       = r_q;
  assign sample_valid_o = valid_q;
  assign clip_o         = clip_q;

endmodule

// File: tb/tb_audio_mix_stage.sv
// Directed bench for audio_mix_stage with a scaled-down clock
// (2700 Hz clk, 441 Hz samples, 10-sample speaker hold).
module tb_audio_mix_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ssp = '0;
  logic [9:0]  mbl = '0, mbr = '0;
  logic        speaker = 1'b0;
  logic [3:0]  gs = 4'd8, gm = 4'd8, gk = 4'd8;
  logic        mute = 1'b0;
  logic [15:0] core_l_o, core_r_o;
  logic        sample_valid_o, clip_o;

  int checks = 0;
  int errors = 0;

  audio_mix_stage #(
    .CLK_RATE(2700),
    .SAMPLE_RATE(441),
    .SPK_HOLD_SAMPLES(10),
    .SPK_LEVEL(16'h2000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ssp_audio_i(ssp),
    .mb_audio_l_i(mbl),
    .mb_audio_r_i(mbr),
    .speaker_i(speaker),
    .ssp_gain_i(gs),
    .mb_gain_i(gm),
    .spk_gain_i(gk),
    .mute_i(mute),
    .core_l_o(core_l_o),
    .core_r_o(core_r_o),
    .sample_valid_o(sample_valid_o),
    .clip_o(clip_o)
  );

  always #5 clk = ~clk;

  // independent tick predictor used only to aim stimulus at tick cycles
  logic [31:0] m_acc;
  logic        m_tick;
  assign m_tick = (m_acc + 32'd441) >= 32'd2700;
  always @(posedge clk) begin
    if (reset) m_acc <= 32'd0;
    else if (m_tick) m_acc <= m_acc + 32'd441 - 32'd2700;
    else m_acc <= m_acc + 32'd441;
  end

  task automatic wait_valid(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sample_valid_o) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_tick(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (m_tick === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic set_in(input logic [15:0] s, input logic [9:0] l,
                        input logic [9:0] r, input logic [3:0] a,
                        input logic [3:0] b, input logic m);
    ssp = s; mbl = l; mbr = r; gs = a; gm = b; mute = m;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (core_l_o !== 16'h0 || core_r_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_out l=%h r=%h exp 0", core_l_o, core_r_o);
    end
    checks++;
    if (sample_valid_o !== 1'b0 || clip_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags v=%b c=%b exp 0", sample_valid_o, clip_o);
    end
  endtask

  task automatic test_tick_rate;
    int first, last, cnt, badgap, nz;
    first = 0; last = 0; cnt = 0; badgap = 0; nz = 0;
    reset = 1'b0;
    for (int n = 1; n <= 2703; n++) begin
      @(posedge clk); #1;
      if (sample_valid_o) begin
        if (first == 0) first = n;
        if (last != 0 && (n - last) != 6 && (n - last) != 7) badgap++;
        last = n;
        cnt++;
      end
      if (core_l_o !== 16'h0 || core_r_o !== 16'h0) nz++;
    end
    checks++;
    if (first != 9) begin
      errors++;
      $display("FAIL first_valid cycle=%0d exp 9", first);
    end
    checks++;
    if (cnt != 441) begin
      errors++;
      $display("FAIL pulse_count got=%0d exp 441", cnt);
    end
    checks++;
    if (badgap != 0) begin
      errors++;
      $display("FAIL spacing bad=%0d exp 0", badgap);
    end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL idle_out nonzero=%0d exp 0", nz);
    end
  endtask

  task automatic test_latency;
    bit to;
    int n;
    set_in(16'h1000, 10'h100, 10'h0, 4'd8, 4'd8, 1'b0);
    wait_valid(to);
    wait_valid(to);
    wait_tick(to);
    n = 99;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (sample_valid_o) begin
        n = i;
        break;
      end
    end
    checks++;
    if (to || n != 3) begin
      errors++;
      $display("FAIL latency got=%0d exp 3", n);
    end
    checks++;
    if (core_l_o !== 16'h3000 || core_r_o !== 16'h1000) begin
      errors++;
      $display("FAIL mix_basic l=%h r=%h exp 3000/1000", core_l_o, core_r_o);
    end
    @(posedge clk); #1;
    checks++;
    if (sample_valid_o !== 1'b0 || core_l_o !== 16'h3000) begin
      errors++;
      $display("FAIL hold v=%b l=%h exp 0/3000", sample_valid_o, core_l_o);
    end
  endtask

  typedef struct {
    logic [15:0] s;
    logic [9:0]  l;
    logic [9:0]  r;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  task automatic test_gains;
    vec_t tv[5];
    bit to;
    tv[0] = '{16'h1000, 10'h100, 10'h000, 4'd8,  4'd8,  16'h3000, 16'h1000};
    tv[1] = '{16'h1000, 10'h100, 10'h080, 4'd0,  4'd8,  16'h2000, 16'h1000};
    tv[2] = '{16'h1000, 10'h100, 10'h000, 4'd15, 4'd3,  16'h2A00, 16'h1E00};
    tv[3] = '{16'h000F, 10'h000, 10'h000, 4'd3,  4'd8,  16'h0005, 16'h0005};
    tv[4] = '{16'h0000, 10'h3FF, 10'h001, 4'd8,  4'd15, 16'hEFC4, 16'h003C};
    for (int i = 0; i < 5; i++) begin
      set_in(tv[i].s, tv[i].l, tv[i].r, tv[i].a, tv[i].b, 1'b0);
      wait_valid(to);
      wait_valid(to);
      checks++;
      if (to || core_l_o !== tv[i].el || core_r_o !== tv[i].er) begin
        errors++;
        $display("FAIL gain_vec%0d l=%h r=%h exp %h/%h",
                 i, core_l_o, core_r_o, tv[i].el, tv[i].er);
      end
    end
    checks++;
    if (clip_o !== 1'b0) begin
      errors++;
      $display("FAIL clip_idle got=%b exp 0", clip_o);
    end
  endtask

  task automatic test_saturation;
    bit to;
    set_in(16'hFFFF, 10'h000, 10'h000, 4'd8, 4'd8, 1'b0);
    wait_valid(to); wait_valid(to);
    checks++;
    if (to || core_l_o !== 16'hFFFF || clip_o !== 1'b0) begin
      errors++;
      $display("FAIL edge_65535 l=%h c=%b exp FFFF/0", core_l_o, clip_o);
    end
    set_in(16'hFFFF, 10'h3FF, 10'h000, 4'd15, 4'd15, 1'b1);
    wait_valid(to); wait_valid(to);
    checks++;
    if (to || core_l_o !== 16'h0 || core_r_o !== 16'h0 || clip_o !== 1'b0) begin
      errors++;
      $display("FAIL mute_sat l=%h r=%h c=%b exp 0/0/0",
               core_l_o, core_r_o, clip_o);
    end
    set_in(16'hFFFF, 10'h001, 10'h000, 4'd8, 4'd8, 1'b0);
    wait_valid(to); wait_valid(to);
    checks++;
    if (to || core_l_o !== 16'hFFFF || core_r_o !== 16'hFFFF || clip_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_by_one l=%h r=%h c=%b exp FFFF/FFFF/1",
               core_l_o, core_r_o, clip_o);
    end
    set_in(16'hFFFF, 10'h3FF, 10'h000, 4'd15, 4'd15, 1'b0);
    wait_valid(to); wait_valid(to);
    checks++;
    if (to || core_l_o !== 16'hFFFF || core_r_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_full l=%h r=%h exp FFFF/FFFF", core_l_o, core_r_o);
    end
    set_in(16'h0000, 10'h000, 10'h000, 4'd15, 4'd15, 1'b0);
    wait_valid(to); wait_valid(to);
    checks++;
    if (to || core_l_o !== 16'h0 || clip_o !== 1'b1) begin
      errors++;
      $display("FAIL clip_sticky l=%h c=%b exp 0/1", core_l_o, clip_o);
    end
    set_in(16'h1000, 10'h000, 10'h000, 4'd8, 4'd8, 1'b1);
    wait_valid(to); wait_valid(to);
    checks++;
    if (to || core_l_o !== 16'h0 || core_r_o !== 16'h0) begin
      errors++;
      $display("FAIL mute l=%h r=%h exp 0/0", core_l_o, core_r_o);
    end
    mute = 1'b0;
  endtask

  task automatic test_input_hold;
    bit to, to2;
    set_in(16'h1000, 10'h000, 10'h000, 4'd8, 4'd8, 1'b0);
    wait_valid(to); wait_valid(to);
    wait_tick(to);
    @(posedge clk); #1;
    ssp = 16'h4000;
    mbl = 10'h3FF;
    wait_valid(to2);
    checks++;
    if (to || to2 || core_l_o !== 16'h1000 || core_r_o !== 16'h1000) begin
      errors++;
      $display("FAIL between_ticks l=%h r=%h exp 1000/1000",
               core_l_o, core_r_o);
    end
    ssp = 16'h1000;
    mbl = 10'h000;
  endtask

  task automatic test_speaker;
    bit to;
    logic [15:0] exp;
    set_in(16'h1000, 10'h000, 10'h000, 4'd8, 4'd8, 1'b0);
    gk = 4'd8;
    wait_valid(to);
    speaker = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      wait_valid(to);
      exp = (i <= 10) ? 16'h3000 : 16'h1000;
      checks++;
      if (to || core_l_o !== exp || core_r_o !== exp) begin
        errors++;
        $display("FAIL spk_hold%0d l=%h r=%h exp %h", i, core_l_o, core_r_o, exp);
      end
    end
    speaker = 1'b0;
    @(posedge clk); #1;
    speaker = 1'b1;
    wait_valid(to);
    checks++;
    if (to || core_l_o !== 16'h3000) begin
      errors++;
      $display("FAIL spk_rearm l=%h exp 3000", core_l_o);
    end
  endtask

  task automatic test_edge_on_tick;
    bit to;
    logic [15:0] exp;
    wait_valid(to);
    speaker = 1'b0;
    for (int i = 1; i <= 9; i++) wait_valid(to);
    checks++;
    if (to || core_l_o !== 16'h1000) begin
      errors++;
      $display("FAIL spk_low l=%h exp 1000", core_l_o);
    end
    wait_tick(to);
    speaker = 1'b1;
    for (int i = 10; i <= 21; i++) begin
      wait_valid(to);
      exp = (i <= 20) ? 16'h3000 : 16'h1000;
      checks++;
      if (to || core_l_o !== exp) begin
        errors++;
        $display("FAIL edge_tick%0d l=%h exp %h", i, core_l_o, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    int first, bad;
    speaker = 1'b0;
    set_in(16'h1000, 10'h000, 10'h000, 4'd8, 4'd8, 1'b0);
    wait_valid(to); wait_valid(to);
    wait_tick(to);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    first = 0; bad = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (sample_valid_o) begin
        first = n;
        break;
      end
      if (core_l_o !== 16'h0 || core_r_o !== 16'h0) bad++;
    end
    checks++;
    if (to || first != 9) begin
      errors++;
      $display("FAIL reset_mid_first got=%0d exp 9", first);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_zero bad=%0d exp 0", bad);
    end
    checks++;
    if (core_l_o !== 16'h1000 || clip_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_out l=%h c=%b exp 1000/0", core_l_o, clip_o);
    end
  endtask

  initial begin
    test_reset;
    test_tick_rate;
    test_latency;
    test_gains;
    test_saturation;
    test_input_hold;
    test_speaker;
    test_edge_on_tick;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
